// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the unified memory port.
//   slave  : arbiter view. It takes the fetch/data requests and the memory
//            responses, and drives grants, valids, read data, the memory
//            request fields and status.
//   master : requester/memory-model view, the mirror image of slave.
// Signals:
//   if_*  fetch requester (req/addr in, gnt/valid/rdata out)
//   d_*   load/store requester (req/we/addr/wdata/be in, gnt/valid/rdata out)
//   mem_* memory port (req/we/addr/wdata/be out, ready/rvalid/rdata in)
//   busy, err_stray  status outputs
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_gnt;
  logic                    if_valid;
  logic [DATA_WIDTH-1:0]   if_rdata;

  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic                    d_gnt;
  logic                    d_valid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_ready;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  logic                    busy;
  logic                    err_stray;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output d_gnt, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output busy, err_stray
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  busy, err_stray
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction may be outstanding at a time. Data wins ties, except that
// after STARVE_LIMIT consecutive data grants made while fetch was waiting,
// fetch is forced through.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mem_port_arbiter_if.slave: requester ports, memory port, busy and
//        err_stray (sticky: a memory response arrived with nothing outstanding)
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StWaitIf,
    StWaitD
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       err_q, err_d;
  logic       pick_d;
  logic       pick_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      starve_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    bus.if_gnt    = 1'b0;
    bus.if_valid  = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.d_valid   = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;

    // Data has priority unless fetch has been passed over STARVE_LIMIT times.
    pick_d  = bus.d_req && !(bus.if_req && (starve_q == Limit));
    pick_if = bus.if_req && !pick_d;

    unique case (state_q)
      StIdle: begin
        // Requests are held off while reset is asserted so every output is quiet.
        if (!rst) begin
          if (pick_d) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_be    = bus.d_be;
            if (bus.mem_ready) begin
              bus.d_gnt = 1'b1;
              state_d   = StWaitD;
              // Only count data wins that actually made fetch wait.
              if (bus.if_req) begin
                starve_d = (starve_q == Limit) ? Limit : starve_q + 4'd1;
              end else begin
                starve_d = 4'd0;
              end
            end
          end else if (pick_if) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = bus.if_addr;
            bus.mem_be   = '1;
            if (bus.mem_ready) begin
              bus.if_gnt = 1'b1;
              state_d    = StWaitIf;
              starve_d   = 4'd0;
            end
          end
        end
      end
      StWaitIf: begin
        if (bus.mem_rvalid) begin
          bus.if_valid = 1'b1;
          state_d      = StIdle;
        end
      end
      StWaitD: begin
        if (bus.mem_rvalid) begin
          bus.d_valid = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A response with nothing outstanding (e.g. one dropped by reset) is flagged.
  assign err_d = err_q | ((state_q == StIdle) && bus.mem_rvalid);

  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.busy      = (state_q != StIdle);
  assign bus.err_stray = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a spec-level reference model that
// is checked on every falling clock edge, plus literal checks of the
// documented scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int          LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  int          lat = 1;
  logic [31:0] resp_data = 32'h0;
  bit          pend = 1'b0;
  int          wc = 0;

  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req && bus.mem_ready) begin
        pend = 1'b1;
        wc   = lat - 1;
      end
      @(posedge clk);
      #1;
      if (pend && wc == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = resp_data;
        pend           = 1'b0;
      end else begin
        if (pend) wc--;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  // owner: 0 = nothing outstanding, 1 = fetch outstanding, 2 = data outstanding
  int owner = 0, owner_n = 0;
  int cnt   = 0, cnt_n   = 0;
  bit stray = 0, stray_n = 0;

  always @(negedge clk) begin
    int          win;
    logic        e_req, e_we, e_ig, e_dg, e_iv, e_dv, e_busy, e_err;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    e_req = 0; e_we = 0; e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0;
    e_busy = 0; e_err = 0; e_addr = 0; e_wdata = 0; e_be = 0;
    owner_n = owner; cnt_n = cnt; stray_n = stray;
    if (rst) begin
      owner_n = 0; cnt_n = 0; stray_n = 0;
    end else begin
      e_busy = (owner != 0);
      e_err  = stray;
      if (owner == 0) begin
        if (bus.mem_rvalid) stray_n = 1;
        if (bus.d_req && !(bus.if_req && cnt == LIMIT)) win = 2;
        else if (bus.if_req) win = 1;
        else win = 0;
        if (win == 2) begin
          e_req = 1; e_we = bus.d_we; e_addr = bus.d_addr;
          e_wdata = bus.d_wdata; e_be = bus.d_be;
        end else if (win == 1) begin
          e_req = 1; e_addr = bus.if_addr; e_be = 4'hF;
        end
        if (win != 0 && bus.mem_ready) begin
          owner_n = win;
          if (win == 2) begin
            e_dg  = 1;
            cnt_n = bus.if_req ? ((cnt < LIMIT) ? cnt + 1 : LIMIT) : 0;
          end else begin
            e_ig  = 1;
            cnt_n = 0;
          end
        end
      end else if (bus.mem_rvalid) begin
        if (owner == 1) e_iv = 1;
        else e_dv = 1;
        owner_n = 0;
      end
    end
    chk("mem_req",   32'(bus.mem_req),  32'(e_req));
    chk("mem_we",    32'(bus.mem_we),   32'(e_we));
    chk("mem_addr",  bus.mem_addr,      e_addr);
    chk("mem_wdata", bus.mem_wdata,     e_wdata);
    chk("mem_be",    32'(bus.mem_be),   32'(e_be));
    chk("if_gnt",    32'(bus.if_gnt),   32'(e_ig));
    chk("d_gnt",     32'(bus.d_gnt),    32'(e_dg));
    chk("if_valid",  32'(bus.if_valid), 32'(e_iv));
    chk("d_valid",   32'(bus.d_valid),  32'(e_dv));
    chk("busy",      32'(bus.busy),     32'(e_busy));
    chk("err_stray", 32'(bus.err_stray), 32'(e_err));
    chk("if_rdata",  bus.if_rdata,      bus.mem_rdata);
    chk("d_rdata",   bus.d_rdata,       bus.mem_rdata);
  end

  always @(posedge clk) begin
    owner = owner_n;
    cnt   = cnt_n;
    stray = stray_n;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  string log;

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_be = 4'h0;
    bus.mem_ready = 1'b1;
    step();
    step();
    // Requests are present during reset but must not reach the memory port.
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err_stray), 32'h0);
    step();
    bus.if_req = 1'b0; bus.d_req = 1'b0; rst = 1'b0;
    step();

    // Single fetch
    lat = 1; resp_data = 32'h0050_0093;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    @(negedge clk);
    chk("fetch_gnt", 32'(bus.if_gnt), 32'h1);
    chk("fetch_we", 32'(bus.mem_we), 32'h0);
    chk("fetch_be", 32'(bus.mem_be), 32'hF);
    chk("fetch_addr", bus.mem_addr, 32'h100);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("fetch_valid", 32'(bus.if_valid), 32'h1);
    chk("fetch_rdata", bus.if_rdata, 32'h0050_0093);
    step();

    // Collision: data first, then fetch
    resp_data = 32'h0;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'h3;
    @(negedge clk);
    chk("coll_d_gnt", 32'(bus.d_gnt), 32'h1);
    chk("coll_if_gnt0", 32'(bus.if_gnt), 32'h0);
    chk("coll_we", 32'(bus.mem_we), 32'h1);
    chk("coll_addr", bus.mem_addr, 32'h20);
    chk("coll_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("coll_be", 32'(bus.mem_be), 32'h3);
    step();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    chk("coll_d_valid", 32'(bus.d_valid), 32'h1);
    chk("coll_no_issue", 32'(bus.mem_req), 32'h0);
    step();
    @(negedge clk);
    chk("coll_if_gnt", 32'(bus.if_gnt), 32'h1);
    chk("coll_if_addr", bus.mem_addr, 32'h104);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("coll_if_valid", 32'(bus.if_valid), 32'h1);
    step();

    // Starvation guard: both requesting continuously with a 1-cycle memory
    log = "";
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.d_gnt) log = {log, "D"};
      if (bus.if_gnt) log = {log, "I"};
      step();
    end
    n_checks++;
    if (log.len() < 10 || log.substr(0, 9) != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL starve_order: got %s, expected DDDDIDDDDI...", log);
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) step();

    // Back-pressure then slow response
    lat = 5; resp_data = 32'hCAFE_0040;
    bus.mem_ready = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_mem_req", 32'(bus.mem_req), 32'h1);
      chk("bp_no_gnt", 32'(bus.d_gnt), 32'h0);
      step();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt", 32'(bus.d_gnt), 32'h1);
    step();
    bus.d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("slow_busy", 32'(bus.busy), 32'h1);
      chk("slow_mem_req", 32'(bus.mem_req), 32'h0);
      step();
    end
    @(negedge clk);
    chk("slow_d_valid", 32'(bus.d_valid), 32'h1);
    chk("slow_rdata", bus.d_rdata, 32'hCAFE_0040);
    step();

    // Idle quiet with random mem_ready
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("quiet_mem_req", 32'(bus.mem_req), 32'h0);
      chk("quiet_busy", 32'(bus.busy), 32'h0);
      step();
    end

    // Reset in WAIT_D; the late response must be flagged as stray
    bus.mem_ready = 1'b1; lat = 5;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h1;
    bus.d_be = 4'hF;
    @(negedge clk);
    chk("rmid_gnt", 32'(bus.d_gnt), 32'h1);
    step();
    bus.d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rmid_busy", 32'(bus.busy), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_idle", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("rmid_no_valid", 32'(bus.d_valid), 32'h0);
    end
    chk("rmid_err", 32'(bus.err_stray), 32'h1);
    step();
    @(negedge clk);
    chk("rmid_err_sticky", 32'(bus.err_stray), 32'h1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_clears_err", 32'(bus.err_stray), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("err_after_rst", 32'(bus.err_stray), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the reduced RISC-V CPU between the instruction-fetch requester (PC path) and the load/store requester (ALU/data path). It serialises accesses with a one-outstanding-transaction FSM and gives data accesses priority, with a starvation guard for fetch. Requesters see per-port grant and response-valid pulses, which the CPU top uses as stall conditions.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- STARVE_LIMIT, 4, consecutive data grants, made while fetch was also requesting, before fetch is forced to win; range 1..15

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with stable if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted by memory this cycle
- if_valid  out  1  fetch response; if_rdata valid this cycle
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request; d_we/d_addr/d_wdata/d_be held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_valid  out  1  data response (load data or store ack)
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory request
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  muxed request fields
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  memory response (also returned for stores)
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  transaction outstanding
- err_stray  out  1  sticky: mem_rvalid seen while IDLE

## Operation
- States: IDLE, WAIT_IF, WAIT_D. Reset -> IDLE, starve_cnt=0, err_stray=0.
- IDLE selection: winner = data if d_req and not (if_req and starve_cnt==STARVE_LIMIT); else fetch if if_req; else none.
- IDLE: mem_req=1 when a winner exists; mem_* fields are muxed combinationally from the winner (fetch: mem_we=0, mem_be=all ones, mem_wdata=0). With no winner, all mem_* fields are 0.
- Accept: mem_req and mem_ready in IDLE -> winner's gnt=1 (combinational, same cycle); next state WAIT_D or WAIT_IF. No accept -> stay IDLE, re-arbitrate next cycle. The winner may change if inputs change.
- starve_cnt updates on accept only:
  - data accepted while if_req=1 -> saturating increment to STARVE_LIMIT
  - fetch accepted -> 0
  - data accepted with if_req=0 -> 0
- WAIT_x: mem_req=0, both gnt=0. On mem_rvalid: x_valid=1 and x_rdata=mem_rdata (combinational); return to IDLE next cycle. No new issue in the response cycle.
- if_rdata/d_rdata carry mem_rdata at all times. They are qualified only by the respective valid.
- busy = (state != IDLE).
- mem_rvalid in IDLE is ignored for valids; err_stray is set the next edge and held until rst.
- rst mid-transaction -> IDLE immediately (async); the outstanding response is dropped and, if it arrives, flags err_stray.

## Timing
- Best-case request -> response: gnt in cycle N, valid in cycle N+1 (mem_rvalid at N+1). Next issue no earlier than N+2.
- Throughput: at most one transaction per 2 cycles.
- All outputs are 0 during and immediately after reset, except rdata, which follows mem_rdata.
- gnt and valid never assert in the same cycle for the same port. At most one gnt and one valid are asserted in any cycle.
- Memory latency is unbounded; the arbiter waits indefinitely in WAIT_x.

## Test plan
- Single fetch: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid next cycle with 0x00500093 -> if_gnt at cycle 0, if_valid with if_rdata=0x00500093 at cycle 1, mem_we=0, mem_be=0xF.
- Collision: if_req=d_req=1 in IDLE, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=0x3 -> d_gnt first with mem fields matching, d_valid on rvalid, then if_gnt at the next IDLE cycle.
- Starvation: both requesting continuously, STARVE_LIMIT=4, 1-cycle memory -> grant order D,D,D,D,IF,D,D,D,D,IF; starve_cnt resets after each IF.
- Back-pressure: mem_ready=0 for 3 cycles with d_req held -> mem_req=1 throughout, no gnt; gnt in the cycle mem_ready rises; slow response (5 cycles) keeps busy=1, mem_req=0.
- Reset mid-op: assert rst in WAIT_D, then deliver mem_rvalid after release -> state IDLE, no d_valid, err_stray=1 until next rst.
- Idle quiet: no requests, random mem_ready -> mem_req=0, no gnt/valid, busy=0.
